// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      HZ_RUN,
      HZ_MD_WAIT,
      HZ_HALT
   } hazard_state_t;

   // $zero is hardwired, so a load targeting it never creates a real dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when an operand is actually read and names the given destination.
   function automatic logic reg_match(input logic       use_f,
                                      input logic [4:0] src,
                                      input logic [4:0] dst);
      return use_f && (src == dst);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Enable-increment counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_d, count_q;

   // Next count: hold at all-ones once reached.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register, cleared by the asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: resolves load-use, mult/div wait, branch flush and syscall halt
// by gating the PC / IF-ID / ID-EX enables and bubbling the pipeline registers.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned MD_MAX_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs_num_id,
   input  logic [4:0]       rt_num_id,
   input  logic             use_rs_id,
   input  logic             use_rt_id,
   input  logic             MemRead_id_ex,
   input  logic [4:0]       regfile_write_num_id_ex,
   input  logic             branch_taken_ex,
   input  logic             muldiv_start_ex,
   input  logic             muldiv_done,
   input  logic             syscall_halt_wb,
   input  logic             resume,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             halted,
   output logic             md_timeout,
   output logic [CNT_W-1:0] load_stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned       TMR_W    = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(MD_MAX_CYCLES - 1);

   hazard_state_t    state_d, state_q;
   logic [TMR_W-1:0] timer_d, timer_q;
   logic             md_timeout_d, md_timeout_q;
   logic             load_use;
   logic             load_stall_inc;
   logic             flush_inc;

   assign load_use = MemRead_id_ex && (regfile_write_num_id_ex != REG_ZERO) &&
                     (reg_match(use_rs_id, rs_num_id, regfile_write_num_id_ex) ||
                      reg_match(use_rt_id, rt_num_id, regfile_write_num_id_ex));

   // Next state and pipeline controls; events are tested in priority order.
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      md_timeout_d   = md_timeout_q;
      pc_en          = 1'b1;
      if_id_en       = 1'b1;
      id_ex_en       = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      load_stall_inc = 1'b0;
      flush_inc      = 1'b0;

      unique case (state_q)
         HZ_HALT: begin
            // Frozen; the resume cycle itself still holds everything.
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            if (resume) begin
               state_d = HZ_RUN;
            end
         end

         HZ_MD_WAIT: begin
            if (syscall_halt_wb) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               state_d  = HZ_HALT;
            end else if (muldiv_done) begin
               state_d = HZ_RUN;
            end else begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               timer_d  = timer_q + TMR_W'(1);
               if (timer_q == TMR_LAST) begin
                  // Give up on the unit rather than hang the core.
                  md_timeout_d = 1'b1;
                  state_d      = HZ_RUN;
               end
            end
         end

         HZ_RUN: begin
            if (syscall_halt_wb) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               state_d  = HZ_HALT;
            end else if (muldiv_start_ex && !muldiv_done) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               id_ex_en = 1'b0;
               timer_d  = '0;
               state_d  = HZ_MD_WAIT;
            end else if (branch_taken_ex) begin
               // Squashing the ID instruction also removes any load-use hazard it had.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               flush_inc   = 1'b1;
            end else if (load_use) begin
               // Hold PC and IF/ID one cycle, push a bubble into EX.
               pc_en          = 1'b0;
               if_id_en       = 1'b0;
               id_ex_flush    = 1'b1;
               load_stall_inc = 1'b1;
            end
         end

         default: begin
            state_d = HZ_RUN;
         end
      endcase
   end

   // State, mult/div timer and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HZ_RUN;
         timer_q      <= '0;
         md_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         md_timeout_q <= md_timeout_d;
      end
   end

   assign halted     = (state_q == HZ_HALT);
   assign md_timeout = md_timeout_q;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .inc_i   (load_stall_inc),
      .count_o (load_stall_count)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .inc_i   (flush_inc),
      .count_o (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model.
module tb_hazard_ctrl;

   localparam int unsigned CW   = 4;
   localparam int unsigned MDM  = 8;
   localparam int          CMAX = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    rs_num_id, rt_num_id, regfile_write_num_id_ex;
   logic          use_rs_id, use_rt_id, MemRead_id_ex, branch_taken_ex;
   logic          muldiv_start_ex, muldiv_done, syscall_halt_wb, resume;
   logic          pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, halted, md_timeout;
   logic [CW-1:0] load_stall_count, flush_count;

   int n_vec = 0;
   int n_bad = 0;

   hazard_ctrl #(
      .CNT_W         (CW),
      .MD_MAX_CYCLES (MDM)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .rs_num_id               (rs_num_id),
      .rt_num_id               (rt_num_id),
      .use_rs_id               (use_rs_id),
      .use_rt_id               (use_rt_id),
      .MemRead_id_ex           (MemRead_id_ex),
      .regfile_write_num_id_ex (regfile_write_num_id_ex),
      .branch_taken_ex         (branch_taken_ex),
      .muldiv_start_ex         (muldiv_start_ex),
      .muldiv_done             (muldiv_done),
      .syscall_halt_wb         (syscall_halt_wb),
      .resume                  (resume),
      .pc_en                   (pc_en),
      .if_id_en                (if_id_en),
      .id_ex_en                (id_ex_en),
      .if_id_flush             (if_id_flush),
      .id_ex_flush             (id_ex_flush),
      .halted                  (halted),
      .md_timeout              (md_timeout),
      .load_stall_count        (load_stall_count),
      .flush_count             (flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the pipeline controls must be, from the hazard rules.
   bit m_halt, m_wait, m_tmo;
   int m_wcnt, m_stall, m_flush;

   always @(negedge clk) begin
      logic [6:0] e;  // {pc, if_id_en, id_ex_en, if_id_flush, id_ex_flush, halted, md_timeout}
      bit         lu;
      if (rst) begin
         m_halt  = 1'b0;
         m_wait  = 1'b0;
         m_tmo   = 1'b0;
         m_wcnt  = 0;
         m_stall = 0;
         m_flush = 0;
      end
      chk("stall_cnt", 32'(load_stall_count), 32'(m_stall));
      chk("flush_cnt", 32'(flush_count), 32'(m_flush));
      e = {5'b11100, m_halt, m_tmo};
      if (!rst) begin
         lu = MemRead_id_ex && (regfile_write_num_id_ex != 5'd0) &&
              ((use_rs_id && rs_num_id == regfile_write_num_id_ex) ||
               (use_rt_id && rt_num_id == regfile_write_num_id_ex));
         if (m_halt) begin
            e[6:4] = 3'b000;
            if (resume) m_halt = 1'b0;
         end else if (syscall_halt_wb) begin
            e[6:4] = 3'b000;
            m_halt = 1'b1;
            m_wait = 1'b0;
         end else if (m_wait) begin
            if (muldiv_done) begin
               m_wait = 1'b0;
            end else begin
               e[6:4] = 3'b000;
               if (m_wcnt == MDM - 1) begin
                  m_tmo  = 1'b1;
                  m_wait = 1'b0;
               end else begin
                  m_wcnt++;
               end
            end
         end else if (muldiv_start_ex && !muldiv_done) begin
            e[6:4] = 3'b000;
            m_wait = 1'b1;
            m_wcnt = 0;
         end else if (branch_taken_ex) begin
            e[3:2] = 2'b11;
            if (m_flush < CMAX) m_flush++;
         end else if (lu) begin
            e[6:5] = 2'b00;
            e[2]   = 1'b1;
            if (m_stall < CMAX) m_stall++;
         end
      end
      chk("ctl", {25'd0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, halted, md_timeout},
          {25'd0, e});
   end

   task automatic idle();
      rs_num_id = 5'd0; rt_num_id = 5'd0; regfile_write_num_id_ex = 5'd0;
      use_rs_id = 1'b0; use_rt_id = 1'b0; MemRead_id_ex = 1'b0; branch_taken_ex = 1'b0;
      muldiv_start_ex = 1'b0; muldiv_done = 1'b0; syscall_halt_wb = 1'b0; resume = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] dst, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt);
      MemRead_id_ex = 1'b1; regfile_write_num_id_ex = dst;
      rs_num_id = rs; use_rs_id = urs; rt_num_id = rt; use_rt_id = urt;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_pc_en", pc_en, 1);
      chk("rst_halted", halted, 0);
      chk("rst_stall_cnt", load_stall_count, 0);

      // lw $8 in EX, add reads $8 as rs
      set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
      #1;
      chk("lu_pc_en", pc_en, 0);
      chk("lu_if_id_en", if_id_en, 0);
      chk("lu_id_ex_flush", id_ex_flush, 1);
      tick(); idle(); #1;
      chk("lu_after_pc_en", pc_en, 1);
      chk("lu_count", load_stall_count, 1);

      // destination $zero never stalls
      do_reset();
      set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      #1 chk("r0_pc_en", pc_en, 1);
      tick(); idle(); #1;
      chk("r0_count", load_stall_count, 0);

      // matching rt that is not read
      set_lu(5'd8, 5'd3, 1'b1, 5'd8, 1'b0);
      #1 chk("unused_rt_pc_en", pc_en, 1);
      tick(); idle();

      // branch squashes a concurrent load-use
      do_reset();
      set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
      branch_taken_ex = 1'b1;
      #1;
      chk("br_if_id_flush", if_id_flush, 1);
      chk("br_id_ex_flush", id_ex_flush, 1);
      chk("br_pc_en", pc_en, 1);
      tick(); idle(); #1;
      chk("br_flush_cnt", flush_count, 1);
      chk("br_stall_cnt", load_stall_count, 0);

      // mult/div: done arrives 5 cycles after start
      do_reset();
      muldiv_start_ex = 1'b1;
      #1 chk("md_start_pc_en", pc_en, 0);
      tick(); muldiv_start_ex = 1'b0;
      repeat (4) tick();
      muldiv_done = 1'b1;
      #1 chk("md_done_pc_en", pc_en, 1);
      tick(); muldiv_done = 1'b0;
      #1 chk("md_after_pc_en", pc_en, 1);
      tick();

      // mult/div timeout after MDM cycles waiting
      muldiv_start_ex = 1'b1;
      tick(); muldiv_start_ex = 1'b0;
      repeat (7) tick();
      chk("tmo_before", md_timeout, 0);
      chk("tmo_before_pc_en", pc_en, 0);
      tick();
      chk("tmo_set", md_timeout, 1);
      chk("tmo_run_pc_en", pc_en, 1);

      // asynchronous reset in the middle of a mult/div wait
      branch_taken_ex = 1'b1;
      tick(); branch_taken_ex = 1'b0;
      muldiv_start_ex = 1'b1;
      tick(); muldiv_start_ex = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_pc_en", pc_en, 1);
      chk("arst_flush_cnt", flush_count, 0);
      chk("arst_tmo", md_timeout, 0);
      tick(); rst = 1'b0;

      // halt, ignored events while halted, then resume
      syscall_halt_wb = 1'b1;
      #1 chk("halt_pc_en", pc_en, 0);
      tick(); syscall_halt_wb = 1'b0;
      #1 chk("halt_halted", halted, 1);
      for (int i = 0; i < 10; i++) begin
         syscall_halt_wb = (i == 2);
         branch_taken_ex = (i == 4);
         muldiv_start_ex = (i == 6);
         tick();
      end
      idle();
      resume = 1'b1;
      #1;
      chk("resume_cycle_pc_en", pc_en, 0);
      chk("resume_cycle_halted", halted, 1);
      tick(); resume = 1'b0;
      #1;
      chk("resumed_halted", halted, 0);
      chk("resumed_pc_en", pc_en, 1);
      tick();

      // syscall outranks an ongoing mult/div wait
      muldiv_start_ex = 1'b1;
      tick(); muldiv_start_ex = 1'b0;
      tick();
      syscall_halt_wb = 1'b1;
      tick(); syscall_halt_wb = 1'b0;
      #1 chk("md_halt_halted", halted, 1);
      resume = 1'b1;
      tick(); resume = 1'b0;

      // 20 consecutive load-use stalls saturate a 4-bit counter
      do_reset();
      set_lu(5'd17, 5'd0, 1'b0, 5'd17, 1'b1);
      repeat (20) tick();
      idle();
      #1 chk("sat_count", load_stall_count, 15);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; pairs with the EX-stage forwarding unit.
- Forwarding consumes in-flight results. This block covers the cases forwarding cannot resolve: load-use stalls, multiply/divide wait, branch flush and syscall halt.
- Drives the PC enable, IF/ID and ID/EX register enables and flushes.
- Keeps saturating performance counters.

Parameters:
CNT_W, 32, width of the performance counters
MD_MAX_CYCLES, 64, maximum cycles spent in MD_WAIT before timeout

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-high reset
rs_num_id  input  5  rs field of the instruction in ID
rt_num_id  input  5  rt field of the instruction in ID
use_rs_id  input  1  ID instruction reads rs
use_rt_id  input  1  ID instruction reads rt
MemRead_id_ex  input  1  instruction in EX is a load
regfile_write_num_id_ex  input  5  destination register of the instruction in EX
branch_taken_ex  input  1  branch/jump resolved taken in EX
muldiv_start_ex  input  1  mult/div issued in EX this cycle
muldiv_done  input  1  mult/div unit result ready
syscall_halt_wb  input  1  halting syscall retiring in WB
resume  input  1  restart request while halted
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID register enable
id_ex_en  output  1  ID/EX register enable
if_id_flush  output  1  clear IF/ID to a bubble
id_ex_flush  output  1  clear ID/EX to a bubble
halted  output  1  core frozen in HALT
md_timeout  output  1  sticky: mult/div exceeded MD_MAX_CYCLES
load_stall_count  output  CNT_W  cycles stalled for load-use
flush_count  output  CNT_W  branch flush events

Behaviour:
- States: RUN, MD_WAIT, HALT. A state register holds the state; enables and flushes are combinational from the state and the current inputs.
- Reset (async, rst=1): state=RUN, halted=0, md_timeout=0, both counters=0, MD_WAIT timer=0. Reset mid-stall or mid-halt returns to RUN immediately.
- Default outputs in RUN with no event: pc_en=if_id_en=id_ex_en=1, both flushes=0.
- Priority, highest first: syscall_halt_wb or state HALT, then mult/div wait, then branch flush, then load-use stall.
- Halt condition: syscall_halt_wb=1 in any state.
  - That cycle: all three enables=0, flushes=0.
  - Next state HALT, halted=1 from the next edge.
- In HALT: all enables=0, flushes=0.
  - resume=1 gives next state RUN and halted=0. The resume cycle itself stays frozen.
  - syscall_halt_wb is ignored while in HALT.
- Mult/div, entry: muldiv_start_ex=1 in RUN.
  - If muldiv_done=0 that cycle: all enables=0 in that same cycle, next state MD_WAIT, timer cleared.
  - If muldiv_done=1 in the same cycle: no stall, stay in RUN.
- In MD_WAIT:
  - Enables=0 until muldiv_done=1. That cycle enables=1 and the next state is RUN.
  - Timer increments each cycle. When timer reaches MD_MAX_CYCLES-1 without done: md_timeout←1 (sticky until rst), next state RUN.
- Branch flush (RUN, no higher event): branch_taken_ex=1 gives if_id_flush=1, id_ex_flush=1, enables=1.
  - A load-use condition in the same cycle is suppressed, because the ID instruction is squashed.
  - flush_count increments.
- Load-use condition:
  - MemRead_id_ex=1 and regfile_write_num_id_ex≠0, and
  - (use_rs_id and rs_num_id==regfile_write_num_id_ex) or (use_rt_id and rt_num_id==regfile_write_num_id_ex).
- Load-use stall (RUN, no higher event): pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1.
  - One cycle only; the next cycle the load has left EX and forwarding covers it.
  - load_stall_count increments.
- Register 0 never causes a stall.
- Counters saturate at all-ones and do not wrap. They increment only in cycles where the corresponding action is actually applied.

Decomposition:
- hazard_pkg: state enum hazard_state_t {HZ_RUN, HZ_MD_WAIT, HZ_HALT}; constant REG_ZERO=5'd0.
- Sub-module sat_counter #(W): enable-increment saturating counter with async reset. Instantiated twice.
- The FSM, hazard compare and output mux live in hazard_ctrl.

Test Plan:
- Load-use: lw writes $8 (EX, MemRead_id_ex=1, dest=8) with add reading $8 as rs in ID → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables=1; load_stall_count=1.
- Register 0 and unused operands:
  - Same as above but dest=0 → no stall, count stays 0.
  - dest=8, rt_num_id=8, use_rt_id=0 → no stall.
- Branch versus load-use: branch_taken_ex=1 while a load-use condition is present → if_id_flush=id_ex_flush=1, pc_en=1; flush_count=1; load_stall_count=0.
- Mult/div wait: muldiv_start_ex pulse, then muldiv_done after 5 cycles → enables=0 for 5 cycles (start cycle plus 4 in MD_WAIT), =1 on the done cycle, state RUN afterwards.
  - With MD_MAX_CYCLES=8 and done never asserted → md_timeout=1 after 8 cycles in MD_WAIT, return to RUN.
- Halt: syscall_halt_wb pulse → enables=0, halted=1 next cycle; held 10 cycles; resume pulse → halted=0 and enables=1 the following cycle.
- Reset in MD_WAIT: rst asserted asynchronously mid-cycle → outputs immediately at RUN defaults, counters=0, md_timeout=0.
- Saturation: with CNT_W=4, 20 consecutive load-use stalls → load_stall_count=15.
